rc_sequencer: RTL
=================

// Module: rc_sequencer
// PURPOSE
//  Sequences the USB receive chain (rc_dpdm -> decode_nrzi -> bitUnstuffer -> bs_decoder -> rc_crc)
//  for the protocol layer. Arms the chain for a handshake or data packet and supervises sync/packet timeouts.
//  Collects EOP/PID/CRC errors, aborts the chain on failure, captures results and acknowledges with pkt_rec.
// PARAMETERS
//  SYNC_TIMEOUT  255  cycles in WAIT_SYNC before sync-timeout abort
//  PKT_TIMEOUT   255  cycles in RECV before packet-timeout abort
//  ABORT_CYCLES  2    cycles abort is held high
//  MAX_RETRY     3    automatic re-arms per request (used only with RC_RETRY_EN)
// PORTS
//  clk            in   1   clock, all logic on posedge
//  rst_n          in   1   asynchronous, active-low reset
//  rx_req         in   1   host: start receive (sampled in IDLE only)
//  rx_type        in   1   host: 0 = handshake, 1 = data; latched with rx_req
//  rx_cancel      in   1   host: cancel in-progress receive
//  got_sync       in   1   chain: sync pattern detected
//  EOP_error      in   1   chain: bad EOP
//  PID_error      in   1   chain: PID check failed
//  CRC_error      in   1   chain: CRC mismatch
//  pkt_status     in   1   chain: 1 = packet RECEIVED
//  rc_hshake      in   8   chain: received handshake PID
//  rc_data        in   64  chain: received data payload
//  receive_hshake out  1   arm chain for handshake
//  receive_data   out  1   arm chain for data
//  abort          out  1   flush all chain stages
//  pkt_rec        out  1   one-cycle ack to rc_crc that result was consumed
//  busy           out  1   high in every state except IDLE
//  rx_done        out  1   one-cycle completion pulse
//  rx_ok          out  1   valid with rx_done: 1 = success
//  rx_err         out  3   valid with rx_done: 0 none, 1 sync TO, 2 pkt TO, 3 EOP, 4 PID, 5 CRC, 6 cancel
//  hshake_out     out  8   captured handshake, held until next capture
//  data_out       out  64  captured payload, held until next capture
//  rx_retries     out  2   retries used by current/last request
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0, including hshake_out, data_out, rx_err and counters.
//  IDLE: on rx_req, latch rx_type, clear cycle counter and retry counter, go to WAIT_SYNC.
//  WAIT_SYNC / RECV: receive_hshake = ~type and receive_data = type, registered and held high.
//  WAIT_SYNC: got_sync -> RECV with counter cleared. Counter == SYNC_TIMEOUT-1 -> ABORT, err 1.
//  RECV:
//   - Priority when inputs coincide: cancel > EOP(3) > PID(4) > CRC(5) > pkt_status > timeout(2).
//   - Any error -> ABORT. pkt_status=1 -> CAPTURE. Counter == PKT_TIMEOUT-1 -> ABORT, err 2.
//  CAPTURE (1 cycle):
//   - hshake_out <= rc_hshake when type=0, else data_out <= rc_data.
//   - pkt_rec=1; next cycle rx_done=1, rx_ok=1, rx_err=0. Then IDLE.
//  ABORT:
//   - receive_* drop the same cycle; abort=1 for exactly ABORT_CYCLES cycles.
//   - Then REPORT: rx_done=1, rx_ok=0, rx_err=code. Then IDLE.
//  rx_cancel in WAIT_SYNC or RECV -> ABORT, err 6. Ignored in IDLE, ABORT, CAPTURE and REPORT.
//  rx_req while busy is ignored and not queued.
//  Counters saturate and never wrap. Width is $clog2(max(SYNC_TIMEOUT, PKT_TIMEOUT)+1).
//  Async reset mid-packet: chain arming is dropped immediately and no rx_done is issued.
// CONFIGURATION
//  RC_RETRY_EN defined:
//   - After ABORT for err 1-5 with rx_retries < MAX_RETRY: increment rx_retries, clear counter, re-enter WAIT_SYNC.
//   - No rx_done is issued for the retried attempt.
//   - Cancel (err 6) never retries. On exhausted retries, REPORT the last error.
//  RC_RETRY_EN undefined: no retry path, rx_retries tied 0, MAX_RETRY unused.
// TESTING
//  1. rx_req, rx_type=0, got_sync @ +8, pkt_status @ +20 with rc_hshake=8'h4B
//     -> pkt_rec 1 cycle, then rx_done/rx_ok=1, hshake_out=8'h4B.
//  2. rx_type=1, rc_data=64'hF77DB57B7D5D7F53 -> data_out matches, receive_data high only WAIT_SYNC..RECV.
//  3. No got_sync, SYNC_TIMEOUT=16 -> abort high 2 cycles starting cycle 16, rx_err=1, rx_ok=0.
//  4. CRC_error and pkt_status in the same RECV cycle -> rx_err=5, no pkt_rec, no capture.
//  5. rx_cancel in RECV -> abort 2 cycles, rx_err=6. rx_req issued during abort is ignored (busy=1).
//  6. RC_RETRY_EN, MAX_RETRY=3, PID_error every attempt
//     -> 4 aborts, single rx_done with rx_err=4, rx_retries=3.
//     Without the macro -> first abort reports, rx_retries=0.

Source files
------------

// File: rtl/rc_sequencer_if.sv
// rc_sequencer_if
//   Host-side request/result bundle of the USB receive-chain sequencer.
//   master : protocol layer (drives rx_req/rx_type/rx_cancel, reads results)
//   slave  : rc_sequencer
// Signals
//   rx_req      host -> seq  start receive (sampled in IDLE only)
//   rx_type     host -> seq  0 = handshake, 1 = data
//   rx_cancel   host -> seq  cancel an in-progress receive
//   busy        seq -> host  high in every state except IDLE
//   rx_done     seq -> host  one-cycle completion pulse
//   rx_ok       seq -> host  valid with rx_done, 1 = success
//   rx_err      seq -> host  valid with rx_done, result code
//   hshake_out  seq -> host  last captured handshake PID
//   data_out    seq -> host  last captured data payload
//   rx_retries  seq -> host  retries used by the current/last request
interface rc_sequencer_if;
  logic        rx_req;
  logic        rx_type;
  logic        rx_cancel;
  logic        busy;
  logic        rx_done;
  logic        rx_ok;
  logic [2:0]  rx_err;
  logic [7:0]  hshake_out;
  logic [63:0] data_out;
  logic [1:0]  rx_retries;

  modport master (
    output rx_req, rx_type, rx_cancel,
    input  busy, rx_done, rx_ok, rx_err, hshake_out, data_out, rx_retries
  );

  modport slave (
    input  rx_req, rx_type, rx_cancel,
    output busy, rx_done, rx_ok, rx_err, hshake_out, data_out, rx_retries
  );
endinterface

// File: rtl/rc_sequencer.sv
// rc_sequencer
//   Arms the USB receive chain (rc_dpdm -> decode_nrzi -> bitUnstuffer ->
//   bs_decoder -> rc_crc) for a handshake or data packet, supervises the
//   sync and packet timeouts, aborts the chain on any error or cancel,
//   captures the received result and acknowledges it with pkt_rec.
// Optional feature
//   RC_RETRY_EN : when defined, errors 1-5 re-arm the chain automatically up
//                 to MAX_RETRY times before the last error is reported.
//                 When undefined there is no retry path and rx_retries is 0.
// Ports
//   clk, rst_n      clock (posedge) and asynchronous active-low reset
//   host            rc_sequencer_if.slave request/result bundle
//   got_sync        chain: sync pattern detected
//   EOP_error       chain: bad EOP
//   PID_error       chain: PID check failed
//   CRC_error       chain: CRC mismatch
//   pkt_status      chain: packet received
//   rc_hshake       chain: received handshake PID
//   rc_data         chain: received data payload
//   receive_hshake  arm chain for handshake
//   receive_data    arm chain for data
//   abort           flush all chain stages
//   pkt_rec         one-cycle ack that the chain result was consumed
module rc_sequencer #(
  parameter int SYNC_TIMEOUT = 255,
  parameter int PKT_TIMEOUT  = 255,
  parameter int ABORT_CYCLES = 2,
  parameter int MAX_RETRY    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  rc_sequencer_if.slave host,
  input  logic          got_sync,
  input  logic          EOP_error,
  input  logic          PID_error,
  input  logic          CRC_error,
  input  logic          pkt_status,
  input  logic [7:0]    rc_hshake,
  input  logic [63:0]   rc_data,
  output logic          receive_hshake,
  output logic          receive_data,
  output logic          abort,
  output logic          pkt_rec
);

  localparam int MAX_TO = (SYNC_TIMEOUT > PKT_TIMEOUT) ? SYNC_TIMEOUT : PKT_TIMEOUT;
  localparam int CW     = $clog2(MAX_TO + 1);

  localparam logic [CW-1:0] SYNC_LAST  = CW'(SYNC_TIMEOUT - 1);
  localparam logic [CW-1:0] PKT_LAST   = CW'(PKT_TIMEOUT - 1);
  localparam logic [CW-1:0] ABORT_LAST = CW'(ABORT_CYCLES - 1);
  localparam logic [1:0]    RETRY_LIM  = 2'(MAX_RETRY);

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_SYNC_TO = 3'd1;
  localparam logic [2:0] ERR_PKT_TO  = 3'd2;
  localparam logic [2:0] ERR_EOP     = 3'd3;
  localparam logic [2:0] ERR_PID     = 3'd4;
  localparam logic [2:0] ERR_CRC     = 3'd5;
  localparam logic [2:0] ERR_CANCEL  = 3'd6;

`ifdef RC_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SYNC,
    RECV,
    CAPTURE,
    DONE,
    ABORT,
    REPORT
  } state_t;

  state_t        state, state_nx;
  logic          type_q, type_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    err_q, err_nx;
  logic [1:0]    retry_q, retry_nx;
  logic          retry_go;

  logic          busy_q, done_q, ok_q;
  logic [2:0]    rx_err_q;
  logic [7:0]    hshake_q;
  logic [63:0]   data_q;

  // Retry is decided when the abort window closes; cancel never retries.
  assign retry_go = RETRY_EN && (err_q != ERR_CANCEL) && (retry_q < RETRY_LIM);

  always_comb begin
    state_nx = state;
    type_nx  = type_q;
    err_nx   = err_q;
    retry_nx = retry_q;
    cnt_nx   = cnt;

    case (state)
      IDLE: begin
        if (host.rx_req) begin
          state_nx = WAIT_SYNC;
          type_nx  = host.rx_type;
          retry_nx = 2'd0;
        end
      end
      WAIT_SYNC: begin
        if (host.rx_cancel) begin
          state_nx = ABORT;
          err_nx   = ERR_CANCEL;
        end else if (got_sync) begin
          state_nx = RECV;
        end else if (cnt == SYNC_LAST) begin
          state_nx = ABORT;
          err_nx   = ERR_SYNC_TO;
        end
      end
      RECV: begin
        // Fixed priority when several chain events land in the same cycle.
        if (host.rx_cancel) begin
          state_nx = ABORT;
          err_nx   = ERR_CANCEL;
        end else if (EOP_error) begin
          state_nx = ABORT;
          err_nx   = ERR_EOP;
        end else if (PID_error) begin
          state_nx = ABORT;
          err_nx   = ERR_PID;
        end else if (CRC_error) begin
          state_nx = ABORT;
          err_nx   = ERR_CRC;
        end else if (pkt_status) begin
          state_nx = CAPTURE;
        end else if (cnt == PKT_LAST) begin
          state_nx = ABORT;
          err_nx   = ERR_PKT_TO;
        end
      end
      CAPTURE: state_nx = DONE;
      DONE:    state_nx = IDLE;
      ABORT: begin
        if (cnt == ABORT_LAST) begin
          if (retry_go) begin
            state_nx = WAIT_SYNC;
            retry_nx = retry_q + 1'b1;
          end else begin
            state_nx = REPORT;
          end
        end
      end
      REPORT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // One counter serves both timeouts and the abort window: it restarts on
    // every state change and saturates instead of wrapping.
    if ((state_nx != state) || (state == IDLE)) begin
      cnt_nx = '0;
    end else if (cnt != '1) begin
      cnt_nx = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      type_q  <= 1'b0;
      cnt     <= '0;
      err_q   <= ERR_NONE;
      retry_q <= 2'd0;
    end else begin
      state   <= state_nx;
      type_q  <= type_nx;
      cnt     <= cnt_nx;
      err_q   <= err_nx;
      retry_q <= retry_nx;
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe and drop in the same cycle the abort rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      receive_hshake <= 1'b0;
      receive_data   <= 1'b0;
      abort          <= 1'b0;
      pkt_rec        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      ok_q           <= 1'b0;
      rx_err_q       <= ERR_NONE;
      hshake_q       <= 8'h00;
      data_q         <= 64'h0;
    end else begin
      receive_hshake <= ((state_nx == WAIT_SYNC) || (state_nx == RECV)) && !type_nx;
      receive_data   <= ((state_nx == WAIT_SYNC) || (state_nx == RECV)) && type_nx;
      abort          <= (state_nx == ABORT);
      pkt_rec        <= (state_nx == CAPTURE);
      busy_q         <= (state_nx != IDLE);
      done_q         <= (state_nx == DONE) || (state_nx == REPORT);
      ok_q           <= (state_nx == DONE);
      if (state_nx == DONE) begin
        rx_err_q <= ERR_NONE;
      end else if (state_nx == REPORT) begin
        rx_err_q <= err_q;
      end
      // Chain result is sampled while pkt_rec acknowledges it.
      if (state == CAPTURE) begin
        if (!type_q) begin
          hshake_q <= rc_hshake;
        end else begin
          data_q <= rc_data;
        end
      end
    end
  end

  assign host.busy       = busy_q;
  assign host.rx_done    = done_q;
  assign host.rx_ok      = ok_q;
  assign host.rx_err     = rx_err_q;
  assign host.hshake_out = hshake_q;
  assign host.data_out   = data_q;
`ifdef RC_RETRY_EN
  assign host.rx_retries = retry_q;
`else
  assign host.rx_retries = 2'b00;
`endif

endmodule
